// File: rtl/pe_norm_pkg.sv
// rtl/pe_norm_pkg.sv - shared norm-unit constants, scheduler state encoding and one-hot helper
package pe_norm_pkg;

    localparam int MAX_REQ = 16;

    localparam logic [7:0] NORM_LAYER = 8'h00;
    localparam logic [7:0] NORM_RMS   = 8'h01;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } sched_state_t;

    function automatic logic [MAX_REQ-1:0] onehot(input int unsigned id);
        onehot = MAX_REQ'(1) << id;
    endfunction

endpackage

// File: rtl/norm_unit_scheduler_if.sv
// rtl/norm_unit_scheduler_if.sv - request/unit/response signal bundle of the norm-unit scheduler
interface norm_unit_scheduler_if #(
    parameter int NUM_REQ = 4
);
    localparam int ID_WIDTH = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_norm_type;
    logic [NUM_REQ-1:0]   req_ready;
    logic [NUM_REQ-1:0]   nu_sel;
    logic                 nu_enable;
    logic [7:0]           nu_norm_type;
    logic                 resp_valid;
    logic [ID_WIDTH-1:0]  resp_id;
    logic                 resp_ready;
    logic                 busy;

    modport master (
        output req_valid, req_norm_type, resp_ready,
        input  req_ready, nu_sel, nu_enable, nu_norm_type, resp_valid, resp_id, busy
    );

    modport slave (
        input  req_valid, req_norm_type, resp_ready,
        output req_ready, nu_sel, nu_enable, nu_norm_type, resp_valid, resp_id, busy
    );

endinterface

// File: rtl/rr_arbiter_comb.sv
// rtl/rr_arbiter_comb.sv - combinational round-robin pick, first request above rr_ptr with wrap
module rr_arbiter_comb #(
    parameter  int NUM_REQ  = 4,
    localparam int ID_WIDTH = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]  req_i,
    input  logic [ID_WIDTH-1:0] rr_ptr_i,
    output logic                grant_valid_o,
    output logic [ID_WIDTH-1:0] grant_id_o
);

    int idx;

    // Scan farthest-to-nearest so the nearest requester after rr_ptr wins last.
    always_comb begin
        grant_valid_o = 1'b0;
        grant_id_o    = '0;
        idx           = 0;
        for (int off = NUM_REQ; off >= 1; off--) begin
            idx = (int'(rr_ptr_i) + off) % NUM_REQ;
            if (req_i[idx]) begin
                grant_valid_o = 1'b1;
                grant_id_o    = ID_WIDTH'(idx);
            end
        end
    end

endmodule

// File: rtl/norm_unit_scheduler.sv
// rtl/norm_unit_scheduler.sv - shares one norm unit among requesters; NORM_SCHED_BYPASS_IDLE_EN re-arbitrates on the response handshake
module norm_unit_scheduler
    import pe_norm_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int NORM_LATENCY = 1
) (
    input logic                  clk,
    input logic                  rst_n,
    norm_unit_scheduler_if.slave bus
);

    localparam int ID_WIDTH = $clog2(NUM_REQ);
    localparam int CNT_W    = $clog2(NORM_LATENCY + 1);

    sched_state_t        state_q;
    logic [ID_WIDTH-1:0] rr_ptr_q;
    logic [ID_WIDTH-1:0] grant_id_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [NUM_REQ-1:0]  req_ready_q;
    logic [NUM_REQ-1:0]  nu_sel_q;
    logic                nu_enable_q;
    logic [7:0]          nu_norm_type_q;
    logic                resp_valid_q;
    logic [ID_WIDTH-1:0] resp_id_q;
    logic                busy_q;

    logic                arb_valid_d;
    logic [ID_WIDTH-1:0] arb_id_d;
    logic [NUM_REQ-1:0]  arb_oh_d;
    logic [7:0]          arb_type_d;

    rr_arbiter_comb #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req_i         (bus.req_valid),
        .rr_ptr_i      (rr_ptr_q),
        .grant_valid_o (arb_valid_d),
        .grant_id_o    (arb_id_d)
    );

    always_comb begin
        arb_oh_d   = NUM_REQ'(onehot(int'(arb_id_d)));
        arb_type_d = bus.req_norm_type[8*arb_id_d +: 8];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            rr_ptr_q       <= ID_WIDTH'(NUM_REQ - 1);
            grant_id_q     <= '0;
            cnt_q          <= '0;
            req_ready_q    <= '0;
            nu_sel_q       <= '0;
            nu_enable_q    <= 1'b0;
            nu_norm_type_q <= '0;
            resp_valid_q   <= 1'b0;
            resp_id_q      <= '0;
            busy_q         <= 1'b0;
        end else begin
            // Issue-cycle outputs are single-cycle pulses.
            req_ready_q <= '0;
            nu_sel_q    <= '0;
            nu_enable_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (arb_valid_d) begin
                        state_q        <= ST_ISSUE;
                        grant_id_q     <= arb_id_d;
                        nu_norm_type_q <= arb_type_d;
                        nu_sel_q       <= arb_oh_d;
                        req_ready_q    <= arb_oh_d;
                        nu_enable_q    <= 1'b1;
                        busy_q         <= 1'b1;
                    end
                end
                ST_ISSUE: begin
                    rr_ptr_q <= grant_id_q;
                    cnt_q    <= CNT_W'(NORM_LATENCY - 1);
                    if (NORM_LATENCY > 1) begin
                        state_q <= ST_WAIT;
                    end else begin
                        state_q      <= ST_RESP;
                        resp_valid_q <= 1'b1;
                        resp_id_q    <= grant_id_q;
                    end
                end
                ST_WAIT: begin
                    if (cnt_q == CNT_W'(1)) begin
                        state_q      <= ST_RESP;
                        resp_valid_q <= 1'b1;
                        resp_id_q    <= grant_id_q;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    if (bus.resp_ready) begin
                        resp_valid_q <= 1'b0;
`ifdef NORM_SCHED_BYPASS_IDLE_EN
                        // rr_ptr already equals the current grant here, so fairness holds.
                        if (arb_valid_d) begin
                            state_q        <= ST_ISSUE;
                            grant_id_q     <= arb_id_d;
                            nu_norm_type_q <= arb_type_d;
                            nu_sel_q       <= arb_oh_d;
                            req_ready_q    <= arb_oh_d;
                            nu_enable_q    <= 1'b1;
                        end else begin
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                        end
`else
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
`endif
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.req_ready    = req_ready_q;
    assign bus.nu_sel       = nu_sel_q;
    assign bus.nu_enable    = nu_enable_q;
    assign bus.nu_norm_type = nu_norm_type_q;
    assign bus.resp_valid   = resp_valid_q;
    assign bus.resp_id      = resp_id_q;
    assign bus.busy         = busy_q;

endmodule

// File: doc/norm_unit_scheduler.md
Name: norm_unit_scheduler

Overview:
Control-only scheduler that shares one normalization unit between NUM_REQ requesters (for example the attention, FFN and residual paths of the PE core).
- Arbitrates round-robin and drives the external data-input mux select.
- Pulses the unit's enable with the requested norm_type.
- Waits out the unit latency, then presents a response handshake tagged with the requester ID.
- Carries no vector data; the unit's output register holds the result stable while enable is low.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
NORM_LATENCY, 1, cycles from the enable cycle to a stable unit output (>=1)
ID_WIDTH, $clog2(NUM_REQ), requester ID width (localparam, not overridable)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
req_valid  in  NUM_REQ  per-requester request; must hold until its req_ready
req_norm_type  in  8*NUM_REQ  per-requester norm type, slice [8*k+7:8*k]; 0=LayerNorm, 1=RMSNorm, other=pass-through
req_ready  out  NUM_REQ  one-hot pulse; the handshake completes on that requester's data sample cycle
nu_sel  out  NUM_REQ  one-hot mux select for the unit's data_i; 0 when not issuing
nu_enable  out  1  unit enable, single-cycle pulse
nu_norm_type  out  8  norm type presented to the unit
resp_valid  out  1  unit output is valid for resp_id
resp_id  out  ID_WIDTH  requester that owns the current result
resp_ready  in  1  consumer accepts the result
busy  out  1  high in any state other than IDLE

Behaviour:
- All outputs are registered. On reset all outputs are 0, state is IDLE, and rr_ptr = NUM_REQ-1, so requester 0 has top priority after reset.
- Reset asserted mid-operation aborts the operation immediately: no response is issued, and the unit's held output is ignored.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req_valid is set, pick the first set bit searching from rr_ptr+1 upward with wrap-around.
  - Latch grant_id and that requester's norm_type, then go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE (exactly 1 cycle):
  - nu_enable=1, nu_sel=onehot(grant_id), nu_norm_type=latched type, req_ready[grant_id]=1.
  - rr_ptr <= grant_id.
  - Next state is WAIT if NORM_LATENCY>1, else RESP.
- WAIT: a down-counter loaded with NORM_LATENCY-1 on ISSUE; go to RESP when it reaches 1. nu_sel=0 and nu_enable=0.
- RESP: resp_valid=1, resp_id=grant_id, held stable until resp_ready.
  - On resp_valid&&resp_ready, go to IDLE (base build).
- Latency with NORM_LATENCY=1:
  - req_valid sampled in cycle 0 (IDLE).
  - ISSUE in cycle 1.
  - resp_valid in cycle 2.
  - Minimum turnaround 3 cycles per operation.
- Boundary conditions:
  - req_valid dropping before its grant is a protocol violation: the grant still issues, and the bench flags it.
  - Unknown norm_type is forwarded unchanged; the unit passes the data through.
  - resp_ready held high before RESP has no effect.
  - A requester whose req_valid stays high is re-served only after all other pending requesters have been served (fairness bound: NUM_REQ-1 intervening grants).
  - A new request arriving during WAIT or RESP waits; there is no preemption.

Optional Feature:
NORM_SCHED_BYPASS_IDLE_EN
- Defined:
  - On the RESP handshake cycle, arbitration is evaluated in parallel using an rr_ptr that already reflects the current grant.
  - If any req_valid is set, go directly to ISSUE, skipping IDLE.
  - Turnaround becomes NORM_LATENCY+1 cycles (2 cycles for the default).
  - The new grant_id and type are latched on that same edge; resp_id updates only after the handshake completes.
- Undefined: always return to IDLE after a response, as in the base behaviour.

Decomposition:
- Shared package pe_norm_pkg:
  - localparams NORM_LAYER=8'h00 and NORM_RMS=8'h01.
  - State encoding enum or localparams for IDLE/ISSUE/WAIT/RESP.
  - Function onehot(id).
- One sub-module: rr_arbiter_comb (combinational round-robin pick).
  - Inputs: req vector, rr_ptr.
  - Outputs: grant_valid, grant_id.
  - Reusable by other shared PE resources.

Test Plan:
1. Reset then single request: req_valid=4'b0100, type=1 → cycle1: nu_enable=1, nu_sel=4'b0100, nu_norm_type=1, req_ready=4'b0100; cycle2: resp_valid=1, resp_id=2; resp_ready=1 → IDLE in cycle3.
2. All four requesting continuously after reset, resp_ready=1 → grant order 0,1,2,3,0; each op 3 cycles apart (2 with NORM_SCHED_BYPASS_IDLE_EN).
3. Backpressure: resp_ready=0 for 5 cycles during RESP → resp_valid and resp_id stable; no nu_enable; a new req_valid=4'b0001 is not granted until after the handshake.
4. NORM_LATENCY=4: enable at cycle1, resp_valid first at cycle5; nu_enable seen exactly once.
5. Reset asserted during WAIT with rr_ptr=2 → next cycle all outputs 0, state IDLE; req_valid=4'b1111 then grants requester 0.
6. req_norm_type=8'h07 → nu_norm_type=8'h07 forwarded; response handshake completes normally.
